gb_serial: RTL and testbench
============================

Name: gb_serial

Overview:
Serial link port, the responder behind the 0xff01–0xff02 IO select produced by the IO address map.
- Holds SB (data, 0xff01) and SC (control, 0xff02) and performs 8-bit MSB-first full-duplex shift transfers.
- Clocking is either an internal clock divided from the system clock or an external link clock.
- Raises a one-cycle serial interrupt request to the interrupt-flag logic when a transfer completes.

Parameters:
- CLK_DIV, 512, system clocks per serial bit in internal-clock mode. Must be even and ≥4. The default gives 8192 Hz at 4.194304 MHz.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  synchronous active-low reset
- sel_ser  input  1  IO select for 0xff01–0xff02, from the IO map
- adr  input  2  low address bits: 2'b01 = SB, 2'b10 = SC; other values are ignored
- din  input  8  CPU write data
- write  input  1  write strobe; takes effect when sel_ser & write on a clock edge
- read  input  1  read strobe
- dout  output  8  read data, combinational; 8'h00 unless sel_ser & read & adr is valid
- sin  input  1  serial data in, from the link
- sout  output  1  serial data out, to the link
- sclk_in  input  1  external link clock, asynchronous
- sclk_out  output  1  internal link clock
- sclk_oe  output  1  drive enable for sclk_out; equals SC bit0
- irq  output  1  serial interrupt request, one-cycle pulse

Behaviour:
Reset values (reset_n low at a clock edge):
- sb = 8'h00, sc_start = 0, sc_int = 0, state = IDLE.
- sout = 1, sclk_out = 1, irq = 0, divider = 0, bitcnt = 0.
- Both sclk_in sync flops = 1.
- A reset mid-transfer aborts the transfer silently; no irq is produced.

Register access:
- SC read returns {sc_start, 6'b111111, sc_int}. SB read returns the current sb, which shows partially shifted contents mid-transfer.
- Reads have no side effects.
- SB write while IDLE loads sb = din. SB write while XFER is ignored.
- SC write with din[7]=1 while IDLE:
  - sc_int = din[0], sc_start = 1.
  - Enter XFER, divider = 0, bitcnt = 0.
- SC write with din[7]=1 while XFER: ignored entirely. No restart and no change to sc_int.
- SC write with din[7]=0 updates sc_int = din[0] and clears sc_start.
  - If in XFER, abort: IDLE, sclk_out = 1, bitcnt = 0, sb keeps its partial value, no irq.

States:
- IDLE: divider and bitcnt held at 0; sclk_out = 1.
- XFER: shifting in progress.

Bit timing, internal mode (sc_int = 1):
- divider counts 0..CLK_DIV-1 and wraps.
- Falling edge at divider == CLK_DIV/2-1: sclk_out <= 0, sout <= sb[7].
- Rising edge at divider == CLK_DIV-1: sclk_out <= 1, sb <= {sb[6:0], sin}, bitcnt++.

Bit timing, external mode (sc_int = 0):
- sclk_in passes through 2-flop synchronizer s1 -> s2, with s2 delayed into s3.
- Falling edge (s3 = 1, s2 = 0): sout <= sb[7].
- Rising edge (s3 = 0, s2 = 1): sb shifts in sin, bitcnt++.
- The divider is unused; sclk_out stays 1.
- Edges detected while IDLE are ignored.

Completion:
- On the rising-edge event that makes bitcnt reach 8, in the same clock: sc_start <= 0, state <= IDLE, irq <= 1.
- irq returns to 0 on the next clock.
- In internal mode irq is high exactly 8*CLK_DIV cycles after the SC start-write edge.
- sout keeps the last bit driven after completion.

Other rules:
- If an SC write coincides with the completing clock, the write wins: its fields are applied and irq is still pulsed.
- sin is sampled directly at the shift edge. It is not synchronized; the link partner holds it stable around sclk rising edges.

Test Plan:
- Reset, then read SC and SB -> SC = 8'h7E, SB = 8'h00, sout = 1, sclk_out = 1, irq = 0.
- CLK_DIV = 4, loopback sin = sout, write SB = 8'hA5, then SC = 8'h81 -> sclk_out toggles 8 times, irq high for 1 cycle exactly 32 cycles after the SC write, SB reads 8'hA5, SC reads 8'h7F.
- CLK_DIV = 4, sin tied 0, SB = 8'hFF, SC = 8'h81 -> sout sequence 1,1,1,1,1,1,1,1, final SB = 8'h00, irq pulse once.
- External mode: SB = 8'h3C, SC = 8'h80; drive 8 sclk_in pulses (8 cycles low, 8 high) with sin = 1 -> sout presents 0,0,1,1,1,1,0,0 on falling edges, SB = 8'hFF, irq once, sclk_oe = 0 throughout.
- Abort and ignored writes: start an internal transfer, write SB = 8'h11 after 3 bits (ignored), then SC = 8'h01 -> no irq, SC = 8'h7F... read shows sc_start = 0, sclk_out = 1, SB holds a 3-bit-shifted value.
- Reset mid-transfer (reset_n low 1 cycle after bit 4) -> all reset values restored, no irq in the following 10*CLK_DIV cycles.

Source files
------------

// File: rtl/gb_serial.sv
// rtl/gb_serial.sv - serial link port: SB/SC registers, 8-bit MSB-first duplex shifter, irq on completion
module gb_serial #(
  parameter int CLK_DIV = 512
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sel_ser,
  input  logic [1:0] adr,
  input  logic [7:0] din,
  input  logic       write,
  input  logic       read,
  output logic [7:0] dout,
  input  logic       sin,
  output logic       sout,
  input  logic       sclk_in,
  output logic       sclk_out,
  output logic       sclk_oe,
  output logic       irq
);

  typedef enum logic {IDLE, XFER} state_t;
  localparam int DW = $clog2(CLK_DIV);

  state_t        state, state_nx;
  logic [7:0]    sb, sb_nx;
  logic          sc_start, sc_start_nx, sc_int, sc_int_nx;
  logic [DW-1:0] divider, divider_nx;
  logic [3:0]    bitcnt, bitcnt_nx;
  logic          sout_nx, sclk_out_nx, irq_nx;
  logic          s1, s2, s3;
  logic          fall_ev, rise_ev;
  logic          wr_sb, wr_sc;

  assign wr_sb   = sel_ser & write & (adr == 2'b01);
  assign wr_sc   = sel_ser & write & (adr == 2'b10);
  assign sclk_oe = sc_int;

  always_comb begin
    dout = 8'h00;
    if (sel_ser & read) begin
      case (adr)
        2'b01:   dout = sb;
        2'b10:   dout = {sc_start, 6'b111111, sc_int};
        default: dout = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    sb_nx       = sb;
    sc_start_nx = sc_start;
    sc_int_nx   = sc_int;
    divider_nx  = divider;
    bitcnt_nx   = bitcnt;
    sout_nx     = sout;
    sclk_out_nx = sclk_out;
    irq_nx      = 1'b0;
    fall_ev     = 1'b0;
    rise_ev     = 1'b0;
    if (state == XFER) begin
      if (sc_int) begin
        fall_ev    = (divider == DW'(CLK_DIV/2 - 1));
        rise_ev    = (divider == DW'(CLK_DIV - 1));
        divider_nx = rise_ev ? '0 : divider + DW'(1);
      end else begin
        fall_ev = s3 & ~s2;
        rise_ev = ~s3 & s2;
      end
      if (fall_ev) begin
        sout_nx = sb[7];
        if (sc_int) sclk_out_nx = 1'b0;
      end
      if (rise_ev) begin
        sb_nx       = {sb[6:0], sin};
        bitcnt_nx   = bitcnt + 4'd1;
        sclk_out_nx = 1'b1;
        if (bitcnt == 4'd7) begin
          state_nx    = IDLE;
          sc_start_nx = 1'b0;
          irq_nx      = 1'b1;
          divider_nx  = '0;
          bitcnt_nx   = 4'd0;
        end
      end
    end
    if (wr_sb && state == IDLE) sb_nx = din;
    // CPU writes are applied after the shift logic so a coinciding SC write wins.
    if (wr_sc) begin
      if (din[7]) begin
        if (state == IDLE) begin
          sc_int_nx   = din[0];
          sc_start_nx = 1'b1;
          state_nx    = XFER;
          divider_nx  = '0;
          bitcnt_nx   = 4'd0;
        end
      end else begin
        sc_int_nx   = din[0];
        sc_start_nx = 1'b0;
        if (state == XFER) begin
          state_nx    = IDLE;
          sclk_out_nx = 1'b1;
          divider_nx  = '0;
          bitcnt_nx   = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      sb       <= 8'h00;
      sc_start <= 1'b0;
      sc_int   <= 1'b0;
      divider  <= '0;
      bitcnt   <= 4'd0;
      sout     <= 1'b1;
      sclk_out <= 1'b1;
      irq      <= 1'b0;
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
    end else begin
      state    <= state_nx;
      sb       <= sb_nx;
      sc_start <= sc_start_nx;
      sc_int   <= sc_int_nx;
      divider  <= divider_nx;
      bitcnt   <= bitcnt_nx;
      sout     <= sout_nx;
      sclk_out <= sclk_out_nx;
      irq      <= irq_nx;
      s1       <= sclk_in;
      s2       <= s1;
      s3       <= s2;
    end
  end

endmodule

// File: tb/tb_gb_serial.sv
// tb/tb_gb_serial.sv - directed bench for gb_serial with a time-based reference model
module tb_gb_serial;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sel_ser = 1'b0;
  logic [1:0] adr = 2'b00;
  logic [7:0] din = 8'h00;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] dout;
  logic       sin;
  logic       sout;
  logic       sclk_in = 1'b1;
  logic       sclk_out;
  logic       sclk_oe;
  logic       irq;
  logic       loop = 1'b0;
  logic       sin_val = 1'b0;

  assign sin = loop ? sout : sin_val;

  gb_serial #(.CLK_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .sel_ser(sel_ser), .adr(adr), .din(din),
    .write(write), .read(read), .dout(dout), .sin(sin), .sout(sout),
    .sclk_in(sclk_in), .sclk_out(sclk_out), .sclk_oe(sclk_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: events derived from elapsed time since start (internal) or
  // from the sclk_in sample history (external), not from a divider counter.
  logic       mvalid = 1'b0;
  logic [7:0] m_sb;
  logic       m_start, m_int, m_busy, m_sout, m_sclk, m_irq;
  logic [2:0] hist;
  int         t, bits;

  always @(posedge clk) begin
    logic fall, rise, busy0;
    cyc++;
    m_irq = 1'b0;
    if (!reset_n) begin
      mvalid = 1'b1;
      m_sb = 8'h00; m_start = 1'b0; m_int = 1'b0; m_busy = 1'b0;
      m_sout = 1'b1; m_sclk = 1'b1; hist = 3'b111; t = 0; bits = 0;
    end else begin
      busy0 = m_busy;
      fall = 1'b0;
      rise = 1'b0;
      if (m_busy) begin
        if (m_int) begin
          t++;
          fall = (t % DIV) == DIV/2;
          rise = (t % DIV) == 0;
        end else begin
          fall = hist[2] & ~hist[1];
          rise = ~hist[2] & hist[1];
        end
      end
      if (fall) begin
        m_sout = m_sb[7];
        if (m_int) m_sclk = 1'b0;
      end
      if (rise) begin
        m_sb = {m_sb[6:0], sin};
        m_sclk = 1'b1;
        bits++;
        if (bits == 8) begin
          m_busy = 1'b0; m_start = 1'b0; m_irq = 1'b1;
        end
      end
      if (sel_ser && write && adr == 2'b01 && !busy0) m_sb = din;
      if (sel_ser && write && adr == 2'b10) begin
        if (din[7]) begin
          if (!busy0) begin
            m_int = din[0]; m_start = 1'b1; m_busy = 1'b1; t = 0; bits = 0;
          end
        end else begin
          m_int = din[0]; m_start = 1'b0;
          if (busy0) begin
            m_busy = 1'b0; m_sclk = 1'b1;
          end
        end
      end
      hist = {hist[1:0], sclk_in};
    end
  end

  int         irq_count = 0;
  int         nlog = 0;
  logic [7:0] slog = 8'h00;
  logic       prev_sclk = 1'b1;

  always @(negedge clk) begin
    logic [7:0] exp_dout;
    if (mvalid) begin
      chk("sout", sout, m_sout);
      chk("sclk_out", sclk_out, m_sclk);
      chk("irq", irq, m_irq);
      chk("sclk_oe", sclk_oe, m_int);
      exp_dout = 8'h00;
      if (sel_ser && read && adr == 2'b01) exp_dout = m_sb;
      if (sel_ser && read && adr == 2'b10) exp_dout = {m_start, 6'b111111, m_int};
      chk("dout", dout, exp_dout);
      if (irq === 1'b1) irq_count++;
      if (prev_sclk === 1'b1 && sclk_out === 1'b0) begin
        slog = {slog[6:0], sout};
        nlog++;
      end
      prev_sclk = sclk_out;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    sel_ser = 1'b1; write = 1'b1; adr = a; din = d;
    @(posedge clk);
    #1;
    sel_ser = 1'b0; write = 1'b0; adr = 2'b00; din = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    sel_ser = 1'b1; read = 1'b1; adr = a;
    @(negedge clk);
    #1;
    d = dout;
    @(posedge clk);
    #1;
    sel_ser = 1'b0; read = 1'b0; adr = 2'b00;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] xlog;
    logic       oe_any;
    int         wr_cyc, irq_cyc;
    bit         got;

    tick(2);
    reset_n = 1'b1;
    tick(1);
    rd(2'b10, v); chk("reset_sc", v, 8'h7E);
    rd(2'b01, v); chk("reset_sb", v, 8'h00);
    chk("reset_sout", sout, 1'b1);
    chk("reset_sclk", sclk_out, 1'b1);
    chk("reset_irq", irq, 1'b0);

    // Internal loopback of 0xA5
    loop = 1'b1;
    wr(2'b01, 8'hA5);
    irq_count = 0; nlog = 0;
    wr(2'b10, 8'h81);
    wr_cyc = cyc;
    got = 0; irq_cyc = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (irq === 1'b1) begin
        got = 1;
        irq_cyc = cyc;
      end
    end
    chk("loop_irq_seen", got, 1'b1);
    chk("loop_irq_delay", irq_cyc - wr_cyc, 32);
    tick(3);
    chk("loop_irq_count", irq_count, 1);
    chk("loop_falls", nlog, 8);
    chk("loop_sout_seq", slog, 8'hA5);
    rd(2'b01, v); chk("loop_sb", v, 8'hA5);
    rd(2'b10, v); chk("loop_sc", v, 8'h7F);
    loop = 1'b0;

    // sin tied low, SB = 0xFF
    sin_val = 1'b0;
    wr(2'b01, 8'hFF);
    irq_count = 0; nlog = 0;
    wr(2'b10, 8'h81);
    tick(8 * DIV + 4);
    chk("zero_falls", nlog, 8);
    chk("zero_sout_seq", slog, 8'hFF);
    chk("zero_irq_count", irq_count, 1);
    rd(2'b01, v); chk("zero_sb", v, 8'h00);

    // External clock, SB = 0x3C, sin high
    sin_val = 1'b1;
    wr(2'b10, 8'h00);
    wr(2'b01, 8'h3C);
    irq_count = 0; oe_any = 1'b0; xlog = 8'h00;
    wr(2'b10, 8'h80);
    for (int b = 0; b < 8; b++) begin
      sclk_in = 1'b0;
      for (int i = 0; i < 8; i++) begin tick(1); oe_any |= sclk_oe; end
      xlog = {xlog[6:0], sout};
      sclk_in = 1'b1;
      for (int i = 0; i < 8; i++) begin tick(1); oe_any |= sclk_oe; end
    end
    tick(4);
    chk("ext_sout_seq", xlog, 8'h3C);
    chk("ext_oe", oe_any, 1'b0);
    chk("ext_irq_count", irq_count, 1);
    rd(2'b01, v); chk("ext_sb", v, 8'hFF);
    rd(2'b10, v); chk("ext_sc", v, 8'h7E);

    // Abort after 3 bits with an ignored SB write in between
    sin_val = 1'b0;
    wr(2'b01, 8'hC3);
    irq_count = 0;
    wr(2'b10, 8'h81);
    tick(13);
    wr(2'b01, 8'h11);
    wr(2'b10, 8'h01);
    tick(10 * DIV);
    chk("abort_irq_count", irq_count, 0);
    chk("abort_sclk", sclk_out, 1'b1);
    rd(2'b10, v); chk("abort_sc", v, 8'h7F);
    rd(2'b01, v); chk("abort_sb", v, 8'h18);

    // Reset one cycle after bit 4
    wr(2'b01, 8'h5A);
    irq_count = 0;
    wr(2'b10, 8'h81);
    tick(4 * DIV + 1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    rd(2'b01, v); chk("rst_sb", v, 8'h00);
    rd(2'b10, v); chk("rst_sc", v, 8'h7E);
    chk("rst_sout", sout, 1'b1);
    chk("rst_sclk", sclk_out, 1'b1);
    tick(10 * DIV);
    chk("rst_irq_count", irq_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
